wave_monitor: RTL and testbench

- Receive-side counterpart to the team's stimulus generators, which toggle a signal with `forever #N`.
- Samples one single-bit waveform against the system clock and measures its period and high time in clock cycles.
- Flags stuck or out-of-tolerance signals against an expected period.
- Sits beside a DUT output (e.g. a gate output) so benches and silicon self-check waveforms instead of relying on VCD inspection.

---
 rtl/wave_pkg.sv | 8 +
 rtl/sync_edge_det.sv | 22 ++
 rtl/wave_monitor.sv | 104 ++++++++++
 tb/tb_wave_monitor.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// wave_pkg: shared state encoding and default parameters for waveform monitors
package wave_pkg;
    typedef enum logic {WAIT_RISE, MEASURE} state_t;
    localparam int CW_DEF          = 16;
    localparam int EXP_PERIOD_DEF  = 20;
    localparam int TOL_DEF         = 1;
    localparam int STUCK_LIMIT_DEF = 1000;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchroniser plus history flop giving level, rise and fall
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic s,
    output logic rise,
    output logic fall
);
    logic s1, s_d;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {s1, s, s_d} <= '0;
        end else begin
            s1  <= sig_in;
            s   <= s1;
            s_d <= s;
        end
    end
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;
endmodule

// File: rtl/wave_monitor.sv
// wave_monitor: measures period/high time of an async waveform and flags
// out-of-tolerance, stuck and counter-overflow conditions
module wave_monitor import wave_pkg::*; #(
    parameter int CW          = CW_DEF,
    parameter int EXP_PERIOD  = EXP_PERIOD_DEF,
    parameter int TOL         = TOL_DEF,
    parameter int STUCK_LIMIT = STUCK_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sig_in,
    input  logic          enable,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_time,
    output logic          meas_valid,
    output logic          mismatch,
    output logic          stuck,
    output logic          overflow
);
    localparam int IW = $clog2(STUCK_LIMIT + 1);
    localparam logic [CW-1:0] MAX = '1;

    state_t          state;
    logic [CW-1:0]   per_cnt, hi_cnt;
    logic            hi_done;
    logic [IW-1:0]   idle_cnt;
    logic            rise, fall;
    logic signed [CW:0] diff, mag;
    logic            off_tol;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .sig_in(sig_in),
        .s     (),
        .rise  (rise),
        .fall  (fall)
    );

    // one extra bit keeps the deviation signed without wrapping
    assign diff    = $signed({1'b0, per_cnt}) - $signed((CW+1)'(EXP_PERIOD));
    assign mag     = diff < 0 ? -diff : diff;
    assign off_tol = mag > $signed((CW+1)'(TOL));
    assign stuck   = idle_cnt >= IW'(STUCK_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= WAIT_RISE;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            hi_done    <= 1'b0;
            idle_cnt   <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            mismatch   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            overflow   <= 1'b0;
            if (!enable) begin
                state    <= WAIT_RISE;
                per_cnt  <= '0;
                hi_cnt   <= '0;
                hi_done  <= 1'b0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= (rise || fall) ? '0 : (stuck ? idle_cnt : idle_cnt + 1'b1);
                case (state)
                    WAIT_RISE: begin
                        if (rise) begin
                            state   <= MEASURE;
                            per_cnt <= CW'(1);
                            hi_cnt  <= CW'(1);
                            hi_done <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        // saturation wins over a coincident rise
                        if (per_cnt == MAX) begin
                            overflow <= 1'b1;
                            state    <= WAIT_RISE;
                            per_cnt  <= '0;
                            hi_cnt   <= '0;
                        end else if (rise) begin
                            period     <= per_cnt;
                            high_time  <= hi_cnt;
                            meas_valid <= 1'b1;
                            mismatch   <= mismatch | off_tol;
                            per_cnt    <= CW'(1);
                            hi_cnt     <= CW'(1);
                            hi_done    <= 1'b0;
                        end else begin
                            per_cnt <= per_cnt + 1'b1;
                            hi_done <= hi_done | fall;
                            if (!hi_done && !fall) hi_cnt <= hi_cnt + 1'b1;
                        end
                    end
                    default: state <= WAIT_RISE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wave_monitor.sv
// tb_wave_monitor: randomized and directed checks of wave_monitor against a
// timestamp-based reference model (default CW and a CW=6 instance)
module tb_wave_monitor;
    localparam int EXP = 20;
    localparam int TOL = 1;
    localparam int LIM = 1000;

    logic clk = 0, rst_n, sig_in, enable;
    logic [15:0] pa, ha;
    logic [5:0]  pb, hb;
    logic mva, misa, sta, ova, mvb, misb, stb, ovb;

    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    wave_monitor #(.CW(16), .EXP_PERIOD(EXP), .TOL(TOL), .STUCK_LIMIT(LIM)) dut_a (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
        .period(pa), .high_time(ha), .meas_valid(mva), .mismatch(misa),
        .stuck(sta), .overflow(ova)
    );

    wave_monitor #(.CW(6), .EXP_PERIOD(EXP), .TOL(TOL), .STUCK_LIMIT(LIM)) dut_b (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
        .period(pb), .high_time(hb), .meas_valid(mvb), .mismatch(misb),
        .stuck(stb), .overflow(ovb)
    );

    // Reference model: edges are timestamped by clk edge number; a transition
    // sampled at edge n is acted upon at edge n+2 (two sync flops + history).
    int  cyc = 0, last_ev = 0;
    bit  armed = 0;
    bit  h1, h2, h3, r, f;
    int  maxc [2] = '{65535, 63};
    bit  meas [2], fell [2];
    int  t_rise [2], t_fall [2];
    int  e_per [2], e_hi [2];
    bit  e_mv [2], e_ov [2], e_mis [2];
    bit  e_stuck;
    int  p;

    always @(posedge clk) begin
        cyc++;
        r = h2 & ~h3;
        f = ~h2 & h3;
        h3 = h2; h2 = h1; h1 = sig_in;
        for (int k = 0; k < 2; k++) begin e_mv[k] = 0; e_ov[k] = 0; end
        if (!rst_n) begin
            h1 = 0; h2 = 0; h3 = 0;
            armed = 1;
            last_ev = cyc;
            for (int k = 0; k < 2; k++) begin
                meas[k] = 0; e_per[k] = 0; e_hi[k] = 0; e_mis[k] = 0;
            end
        end else if (!enable) begin
            last_ev = cyc;
            for (int k = 0; k < 2; k++) meas[k] = 0;
        end else begin
            if (r || f) last_ev = cyc;
            for (int k = 0; k < 2; k++) begin
                if (meas[k]) begin
                    if (cyc - t_rise[k] == maxc[k]) begin
                        e_ov[k] = 1;
                        meas[k] = 0;
                    end else if (r) begin
                        p = cyc - t_rise[k];
                        e_per[k] = p;
                        e_hi[k] = fell[k] ? t_fall[k] - t_rise[k] : p;
                        e_mv[k] = 1;
                        if (p > EXP + TOL || p < EXP - TOL) e_mis[k] = 1;
                        t_rise[k] = cyc;
                        fell[k] = 0;
                    end else if (f && !fell[k]) begin
                        fell[k] = 1;
                        t_fall[k] = cyc;
                    end
                end else if (r) begin
                    meas[k] = 1;
                    t_rise[k] = cyc;
                    fell[k] = 0;
                end
            end
        end
        e_stuck = (cyc - last_ev) >= LIM;
    end

    // Scoreboard on the falling edge, plus pulse bookkeeping for directed tests
    int mv_a = 0, mv_b = 0, ov_b = 0, last_mv = -1, gap_a = 0;
    int ap, ah;
    bit amv, amis, ast, aov;

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                ap  = k ? int'(pb) : int'(pa);
                ah  = k ? int'(hb) : int'(ha);
                amv = k ? mvb : mva;
                amis = k ? misb : misa;
                ast = k ? stb : sta;
                aov = k ? ovb : ova;
                vectors += 6;
                if (ap !== e_per[k]) begin errors++; $display("FAIL sb_period dut%0d cyc %0d got %0d exp %0d", k, cyc, ap, e_per[k]); end
                if (ah !== e_hi[k]) begin errors++; $display("FAIL sb_high dut%0d cyc %0d got %0d exp %0d", k, cyc, ah, e_hi[k]); end
                if (amv !== e_mv[k]) begin errors++; $display("FAIL sb_meas_valid dut%0d cyc %0d got %0b exp %0b", k, cyc, amv, e_mv[k]); end
                if (amis !== e_mis[k]) begin errors++; $display("FAIL sb_mismatch dut%0d cyc %0d got %0b exp %0b", k, cyc, amis, e_mis[k]); end
                if (ast !== e_stuck) begin errors++; $display("FAIL sb_stuck dut%0d cyc %0d got %0b exp %0b", k, cyc, ast, e_stuck); end
                if (aov !== e_ov[k]) begin errors++; $display("FAIL sb_overflow dut%0d cyc %0d got %0b exp %0b", k, cyc, aov, e_ov[k]); end
            end
        end
        if (mva === 1'b1) begin
            if (last_mv >= 0) gap_a = cyc - last_mv;
            last_mv = cyc;
            mv_a++;
        end
        if (mvb === 1'b1) mv_b++;
        if (ovb === 1'b1) ov_b++;
    end

    task automatic cyc_n(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic hold(input bit v, input int n);
        sig_in = v;
        cyc_n(n);
    endtask

    task automatic toggle(input int hi, input int lo, input int reps);
        repeat (reps) begin hold(1, hi); hold(0, lo); end
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        cyc_n(1);
        rst_n = 1;
    endtask

    task automatic test_reset();
        cyc_n(3);
        vectors += 4;
        if ({pa, ha} !== 32'd0) begin errors++; $display("FAIL reset_a_meas got %0d/%0d exp 0/0", pa, ha); end
        if ({mva, misa, sta, ova} !== 4'b0) begin errors++; $display("FAIL reset_a_flags got %b exp 0000", {mva, misa, sta, ova}); end
        if ({pb, hb} !== 12'd0) begin errors++; $display("FAIL reset_b_meas got %0d/%0d exp 0/0", pb, hb); end
        if ({mvb, misb, stb, ovb} !== 4'b0) begin errors++; $display("FAIL reset_b_flags got %b exp 0000", {mvb, misb, stb, ovb}); end
        rst_n = 1;
        cyc_n(2);
    endtask

    task automatic test_nominal();
        int m0 = mv_a;
        toggle(10, 10, 8);
        vectors += 6;
        if (mv_a - m0 !== 7) begin errors++; $display("FAIL nominal_count got %0d exp 7", mv_a - m0); end
        if (gap_a !== 20) begin errors++; $display("FAIL nominal_gap got %0d exp 20", gap_a); end
        if (pa !== 16'd20 || pb !== 6'd20) begin errors++; $display("FAIL nominal_period got %0d/%0d exp 20", pa, pb); end
        if (ha !== 16'd10) begin errors++; $display("FAIL nominal_high got %0d exp 10", ha); end
        if (misa !== 1'b0) begin errors++; $display("FAIL nominal_mismatch got %0b exp 0", misa); end
        if (sta !== 1'b0) begin errors++; $display("FAIL nominal_stuck got %0b exp 0", sta); end
    endtask

    task automatic test_duty();
        toggle(5, 15, 5);
        vectors += 3;
        if (pa !== 16'd20) begin errors++; $display("FAIL duty_period got %0d exp 20", pa); end
        if (ha !== 16'd5 || hb !== 6'd5) begin errors++; $display("FAIL duty_high got %0d/%0d exp 5", ha, hb); end
        if (misa !== 1'b0) begin errors++; $display("FAIL duty_mismatch got %0b exp 0", misa); end
    endtask

    task automatic test_off_freq();
        int m0;
        pulse_reset();
        m0 = mv_a;
        toggle(12, 12, 3);
        vectors += 5;
        if (mv_a - m0 !== 2) begin errors++; $display("FAIL off_count got %0d exp 2", mv_a - m0); end
        if (pa !== 16'd24) begin errors++; $display("FAIL off_period got %0d exp 24", pa); end
        if (misa !== 1'b1) begin errors++; $display("FAIL off_mismatch got %0b exp 1", misa); end
        toggle(10, 10, 4);
        if (pa !== 16'd20) begin errors++; $display("FAIL off_recover_period got %0d exp 20", pa); end
        if (misa !== 1'b1 || misb !== 1'b1) begin errors++; $display("FAIL off_sticky got %0b/%0b exp 1", misa, misb); end
    endtask

    task automatic test_stuck();
        hold(1, 1002);
        vectors += 5;
        if (sta !== 1'b0) begin errors++; $display("FAIL stuck_early got %0b exp 0", sta); end
        cyc_n(1);
        if (sta !== 1'b1 || stb !== 1'b1) begin errors++; $display("FAIL stuck_set got %0b/%0b exp 1", sta, stb); end
        hold(1, 97);
        hold(0, 2);
        if (sta !== 1'b1) begin errors++; $display("FAIL stuck_hold got %0b exp 1", sta); end
        cyc_n(1);
        if (sta !== 1'b0) begin errors++; $display("FAIL stuck_clear got %0b exp 0", sta); end
        hold(0, 1050);
        if (sta !== 1'b1) begin errors++; $display("FAIL stuck_low got %0b exp 1", sta); end
        hold(1, 10);
        hold(0, 10);
    endtask

    task automatic test_overflow();
        int o0, m0;
        pulse_reset();
        o0 = ov_b;
        m0 = mv_b;
        hold(1, 5);
        hold(0, 80);
        vectors += 5;
        if (ov_b - o0 !== 1) begin errors++; $display("FAIL ovf_pulse got %0d exp 1", ov_b - o0); end
        if (pb !== 6'd0) begin errors++; $display("FAIL ovf_period got %0d exp 0", pb); end
        if (mv_b !== m0) begin errors++; $display("FAIL ovf_no_meas got %0d exp %0d", mv_b, m0); end
        toggle(5, 15, 2);
        if (mv_b - m0 !== 1) begin errors++; $display("FAIL ovf_restart_count got %0d exp 1", mv_b - m0); end
        if (pb !== 6'd20 || hb !== 6'd5) begin errors++; $display("FAIL ovf_restart_meas got %0d/%0d exp 20/5", pb, hb); end
    endtask

    task automatic test_reset_enable();
        int m0, p0;
        toggle(10, 10, 3);
        hold(1, 5);
        pulse_reset();
        vectors += 7;
        if ({pa, ha, mva, misa, sta, ova} !== 36'd0) begin errors++; $display("FAIL midreset_outputs got %0d/%0d/%b exp all 0", pa, ha, {mva, misa, sta, ova}); end
        m0 = mv_a;
        hold(1, 5);
        hold(0, 10);
        if (mv_a !== m0) begin errors++; $display("FAIL midreset_first_rise got %0d meas exp 0", mv_a - m0); end
        toggle(10, 10, 1);
        if (mv_a - m0 !== 1) begin errors++; $display("FAIL midreset_second_rise got %0d meas exp 1", mv_a - m0); end
        m0 = mv_a;
        p0 = int'(pa);
        enable = 0;
        cyc_n(5);
        if (int'(pa) !== p0) begin errors++; $display("FAIL disable_hold got %0d exp %0d", pa, p0); end
        if (sta !== 1'b0) begin errors++; $display("FAIL disable_stuck got %0b exp 0", sta); end
        enable = 1;
        toggle(10, 10, 3);
        if (mv_a - m0 !== 2) begin errors++; $display("FAIL enable_restart_count got %0d exp 2", mv_a - m0); end
        if (pa !== 16'd20) begin errors++; $display("FAIL enable_restart_period got %0d exp 20", pa); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            hold(1, int'($urandom_range(30, 2)));
            hold(0, int'($urandom_range(30, 2)));
            if ($urandom_range(9, 0) == 0) begin
                enable = 0;
                cyc_n(int'($urandom_range(4, 1)));
                enable = 1;
            end
        end
    endtask

    initial begin
        rst_n  = 0;
        enable = 1;
        sig_in = 0;
        test_reset();
        test_nominal();
        test_duty();
        test_off_freq();
        test_stuck();
        test_overflow();
        test_reset_enable();
        test_random();
        cyc_n(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
